// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the set-associative cache level.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, DONE} state_t;

  // Zero-width fields still need a 1-bit carrier signal.
  function automatic int minW(input int n);
    return (n > 0) ? n : 1;
  endfunction

  function automatic int offBits(input int blockSize, input int returnSize);
    return $clog2(blockSize / returnSize);
  endfunction

  function automatic int setBits(input int size, input int blockSize, input int assoc);
    return $clog2(size / blockSize / assoc);
  endfunction

  function automatic int unsigned fieldOf(input int unsigned value, input int lsb, input int width);
    return (value >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// Upper/lower-level request bus of one cache level; master is the requester side.
interface assoc_cache_ctrl_if #(
  parameter int ADDR_LENGTH = 10,
  parameter int BLOCK_SIZE  = 32,
  parameter int RETURN_SIZE = 8,
  parameter int STAT_WIDTH  = 16
);
  logic [ADDR_LENGTH-1:0] addr_in;
  logic [BLOCK_SIZE-1:0]  data_in;
  logic                   enable;
  logic                   write;
  logic                   fetchReceive;
  logic [RETURN_SIZE-1:0] data_out;
  logic                   fetchComplete;
  logic                   miss;
  logic [STAT_WIDTH-1:0]  hit_count;
  logic [STAT_WIDTH-1:0]  miss_count;

  modport master (
    output addr_in, data_in, enable, write, fetchReceive,
    input  data_out, fetchComplete, miss, hit_count, miss_count
  );

  modport slave (
    input  addr_in, data_in, enable, write, fetchReceive,
    output data_out, fetchComplete, miss, hit_count, miss_count
  );
endinterface

// File: rtl/cache_lru.sv
// True-LRU age matrix: age 0 is MRU, age WAYS-1 is LRU; ages form a permutation per set.
// Touch updates on the next edge; victim query is combinational from the stored ages.
module cache_lru #(
  parameter int NUM_SETS = 1,
  parameter int WAYS     = 4,
  parameter int SET_W    = 1,
  parameter int WAY_W    = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             touchEn,
  input  logic [SET_W-1:0] touchSet,
  input  logic [WAY_W-1:0] touchWay,
  input  logic [SET_W-1:0] querySet,
  output logic [WAY_W-1:0] victimWay
);
  typedef logic [WAY_W-1:0] age_t;

  age_t age [NUM_SETS][WAYS];

  // Cleared to the identity order so ages stay distinct from the first touch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= age_t'(w);
    end else if (touchEn) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_t'(w) == touchWay)
          age[touchSet][w] <= '0;
        else if (age[touchSet][w] < age[touchSet][touchWay])
          age[touchSet][w] <= age[touchSet][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victimWay = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[querySet][w] == age_t'(WAYS - 1))
        victimWay = age_t'(w);
  end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative cache level: write-around, true-LRU, saturating hit/miss stats.
// Hit done CACHE_DELAY+1 cycles after accept; a miss holds `miss` until the lower level fills.
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int SIZE          = 128,
  parameter int ADDR_LENGTH   = 10,
  parameter int BLOCK_SIZE    = 32,
  parameter int RETURN_SIZE   = 8,
  parameter int ASSOCIATIVITY = 4,
  parameter int CACHE_DELAY   = 0,
  parameter int WRITE_POLICY  = 0,
  parameter int STAT_WIDTH    = 16
) (
  input logic               clk,
  input logic               reset,
  assoc_cache_ctrl_if.slave bus
);
  localparam int NUM_SETS = SIZE / BLOCK_SIZE / ASSOCIATIVITY;
  localparam int OFF_BITS = offBits(BLOCK_SIZE, RETURN_SIZE);
  localparam int SET_BITS = setBits(SIZE, BLOCK_SIZE, ASSOCIATIVITY);
  localparam int TAG_BITS = ADDR_LENGTH - OFF_BITS - SET_BITS;
  localparam int OFF_W    = minW(OFF_BITS);
  localparam int SET_W    = minW(SET_BITS);
  localparam int WAY_W    = $clog2(ASSOCIATIVITY);
  localparam int DCNT_W   = minW($clog2(CACHE_DELAY + 1));
  localparam int BIDX_W   = $clog2(BLOCK_SIZE);

  state_t state, nextState;

  logic [ADDR_LENGTH-1:0] addrQ;
  logic                   writeQ;
  logic [BLOCK_SIZE-1:0]  wdataQ;
  logic [DCNT_W-1:0]      delayCnt;
  logic [WAY_W-1:0]       victimQ;
  logic [RETURN_SIZE-1:0] dataOutQ;
  logic [STAT_WIDTH-1:0]  hitCnt;
  logic [STAT_WIDTH-1:0]  missCnt;

  logic [ASSOCIATIVITY-1:0] valid  [NUM_SETS];
  logic [TAG_BITS-1:0]      tags   [NUM_SETS][ASSOCIATIVITY];
  logic [BLOCK_SIZE-1:0]    blocks [NUM_SETS][ASSOCIATIVITY];

  logic [SET_W-1:0]    setQ;
  logic [TAG_BITS-1:0] tagQ;
  logic [OFF_W-1:0]    selQ;
  logic [BIDX_W-1:0]   sliceLsb;

  assign setQ     = SET_W'(fieldOf(32'(addrQ), OFF_BITS, SET_BITS));
  assign tagQ     = TAG_BITS'(fieldOf(32'(addrQ), OFF_BITS + SET_BITS, TAG_BITS));
  assign selQ     = OFF_W'(fieldOf(32'(addrQ), 0, OFF_BITS));
  assign sliceLsb = BIDX_W'(selQ) * BIDX_W'(RETURN_SIZE);

  logic             hit, freeFound;
  logic [WAY_W-1:0] hitWay, freeWay, lruVictim, touchWay;
  logic             lookupDone, fillDone, touchEn;

  always_comb begin
    hit       = 1'b0;
    hitWay    = '0;
    freeFound = 1'b0;
    freeWay   = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (valid[setQ][w] && tags[setQ][w] == tagQ) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
    end
    // Scan downwards so the lowest-index invalid way wins.
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (!valid[setQ][w]) begin
        freeFound = 1'b1;
        freeWay   = WAY_W'(w);
      end
    end
  end

  assign lookupDone = (state == LOOKUP) && bus.enable && (delayCnt == '0);
  assign fillDone   = (state == FILL) && bus.enable && bus.fetchReceive;
  assign touchEn    = fillDone | (lookupDone & hit & (!writeQ | (WRITE_POLICY == 1)));
  assign touchWay   = fillDone ? victimQ : hitWay;

  cache_lru #(
    .NUM_SETS(NUM_SETS),
    .WAYS    (ASSOCIATIVITY),
    .SET_W   (SET_W),
    .WAY_W   (WAY_W)
  ) u_lru (
    .clk      (clk),
    .reset    (reset),
    .touchEn  (touchEn),
    .touchSet (setQ),
    .touchWay (touchWay),
    .querySet (setQ),
    .victimWay(lruVictim)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.enable) nextState = LOOKUP;
      LOOKUP: begin
        if (!bus.enable)          nextState = IDLE;
        else if (delayCnt == '0)  nextState = (writeQ || hit) ? DONE : FILL;
      end
      FILL: begin
        if (!bus.enable)           nextState = IDLE;
        else if (bus.fetchReceive) nextState = DONE;
      end
      DONE:    if (!bus.enable) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrQ    <= '0;
      writeQ   <= 1'b0;
      wdataQ   <= '0;
      delayCnt <= '0;
      victimQ  <= '0;
      dataOutQ <= '0;
      hitCnt   <= '0;
      missCnt  <= '0;
      for (int s = 0; s < NUM_SETS; s++) valid[s] <= '0;
    end else begin
      if (state == IDLE && bus.enable) begin
        addrQ    <= bus.addr_in;
        writeQ   <= bus.write;
        delayCnt <= DCNT_W'(CACHE_DELAY);
        if (bus.write) wdataQ <= bus.data_in;
      end
      if (state == LOOKUP && bus.enable && delayCnt != '0)
        delayCnt <= delayCnt - 1'b1;
      if (lookupDone) begin
        if (!writeQ) begin
          if (hit) begin
            dataOutQ <= blocks[setQ][hitWay][sliceLsb +: RETURN_SIZE];
            if (hitCnt != '1) hitCnt <= hitCnt + STAT_WIDTH'(1);
          end else begin
            victimQ <= freeFound ? freeWay : lruVictim;
            if (missCnt != '1) missCnt <= missCnt + STAT_WIDTH'(1);
          end
        end else if (hit && WRITE_POLICY == 0) begin
          valid[setQ][hitWay] <= 1'b0;
        end
      end
      if (fillDone) begin
        valid[setQ][victimQ] <= 1'b1;
        dataOutQ             <= bus.data_in[sliceLsb +: RETURN_SIZE];
      end
    end
  end

  // Array contents are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (lookupDone && writeQ && hit && WRITE_POLICY == 1)
      blocks[setQ][hitWay] <= wdataQ;
    if (fillDone) begin
      blocks[setQ][victimQ] <= bus.data_in;
      tags[setQ][victimQ]   <= tagQ;
    end
  end

  assign bus.data_out      = dataOutQ;
  assign bus.fetchComplete = (state == DONE);
  assign bus.miss          = (state == FILL);
  assign bus.hit_count     = hitCnt;
  assign bus.miss_count    = missCnt;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench: default, write-update and delayed-lookup instances share one stimulus bus.
`timescale 1ns/1ps
module tb_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic [9:0]  addr;
  logic [31:0] din;
  logic        en, wr, fr;
  int          sel;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assoc_cache_ctrl_if b0 ();
  assoc_cache_ctrl_if b1 ();
  assoc_cache_ctrl_if b3 ();

  assign b0.addr_in = addr; assign b0.data_in = din; assign b0.enable = en;
  assign b0.write = wr;     assign b0.fetchReceive = fr;
  assign b1.addr_in = addr; assign b1.data_in = din; assign b1.enable = en;
  assign b1.write = wr;     assign b1.fetchReceive = fr;
  assign b3.addr_in = addr; assign b3.data_in = din; assign b3.enable = en;
  assign b3.write = wr;     assign b3.fetchReceive = fr;

  assoc_cache_ctrl u0 (.clk(clk), .reset(rstN), .bus(b0));
  assoc_cache_ctrl #(.WRITE_POLICY(1)) u1 (.clk(clk), .reset(rstN), .bus(b1));
  assoc_cache_ctrl #(.CACHE_DELAY(3))  u3 (.clk(clk), .reset(rstN), .bus(b3));

  logic [7:0]  dOut;
  logic        fc, ms;
  logic [15:0] hc, mc;

  always_comb begin
    case (sel)
      1: begin dOut = b1.data_out; fc = b1.fetchComplete; ms = b1.miss; hc = b1.hit_count; mc = b1.miss_count; end
      3: begin dOut = b3.data_out; fc = b3.fetchComplete; ms = b3.miss; hc = b3.hit_count; mc = b3.miss_count; end
      default: begin dOut = b0.data_out; fc = b0.fetchComplete; ms = b0.miss; hc = b0.hit_count; mc = b0.miss_count; end
    endcase
  end

  typedef struct {
    logic [9:0]  a;
    logic        w;
    logic [31:0] d;
    logic        expMiss;
    logic [7:0]  expData;
    int          expHc;
    int          expMc;
    int          expCyc;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rstN = 1'b0; en = 1'b0; fr = 1'b0; wr = 1'b0;
    tick(); tick();
    rstN = 1'b1;
    tick();
  endtask

  // Holds enable until fetchComplete, supplying the fill as soon as miss shows.
  task automatic doReq(input int s, input logic [9:0] a, input logic w, input logic [31:0] d,
                       output logic sawMiss, output int cyc);
    sel = s; addr = a; wr = w; din = d; en = 1'b1; fr = 1'b0;
    tick();
    cyc = 0;
    sawMiss = 1'b0;
    while (!fc && cyc < 40) begin
      if (ms) begin
        sawMiss = 1'b1;
        fr = 1'b1;
      end
      tick();
      cyc++;
    end
    fr = 1'b0;
  endtask

  task automatic endReq();
    en = 1'b0;
    tick();
  endtask

  logic sawMiss;
  int   cyc;

  initial begin
    sel = 0; addr = '0; din = '0; en = 1'b0; wr = 1'b0; fr = 1'b0; rstN = 1'b0;

    vecs[0]  = '{10'h000, 1'b0, 32'hDDCCBBAA, 1'b1, 8'hAA, 0, 1, 2};
    vecs[1]  = '{10'h001, 1'b0, 32'h00000000, 1'b0, 8'hBB, 1, 1, 1};
    vecs[2]  = '{10'h020, 1'b0, 32'h23222120, 1'b1, 8'h20, 1, 2, 2};
    vecs[3]  = '{10'h040, 1'b0, 32'h43424140, 1'b1, 8'h40, 1, 3, 2};
    vecs[4]  = '{10'h060, 1'b0, 32'h63626160, 1'b1, 8'h60, 1, 4, 2};
    vecs[5]  = '{10'h080, 1'b0, 32'h83828180, 1'b1, 8'h80, 1, 5, 2};
    vecs[6]  = '{10'h021, 1'b0, 32'h00000000, 1'b0, 8'h21, 2, 5, 1};
    vecs[7]  = '{10'h000, 1'b0, 32'hDDCCBBAA, 1'b1, 8'hAA, 2, 6, 2};
    vecs[8]  = '{10'h020, 1'b1, 32'h12345678, 1'b0, 8'hAA, 2, 6, 1};
    vecs[9]  = '{10'h020, 1'b0, 32'h23222120, 1'b1, 8'h20, 2, 7, 2};
    vecs[10] = '{10'h3FC, 1'b1, 32'h0BADF00D, 1'b0, 8'h20, 2, 7, 1};
    vecs[11] = '{10'h062, 1'b0, 32'h63626160, 1'b0, 8'h62, 3, 7, 1};
    vecs[12] = '{10'h041, 1'b0, 32'h43424140, 1'b1, 8'h41, 3, 8, 2};

    tick();
    chk("rst miss", 32'(ms), 32'd0);
    chk("rst done", 32'(fc), 32'd0);
    chk("rst data", 32'(dOut), 32'd0);
    chk("rst hits", 32'(hc), 32'd0);
    chk("rst misses", 32'(mc), 32'd0);
    doReset();

    for (int i = 0; i < NV; i++) begin
      doReq(0, vecs[i].a, vecs[i].w, vecs[i].d, sawMiss, cyc);
      chk($sformatf("v%0d miss", i), 32'(sawMiss), 32'(vecs[i].expMiss));
      chk($sformatf("v%0d done", i), 32'(fc), 32'd1);
      chk($sformatf("v%0d missLow", i), 32'(ms), 32'd0);
      chk($sformatf("v%0d cycles", i), 32'(cyc), 32'(vecs[i].expCyc));
      chk($sformatf("v%0d data", i), 32'(dOut), 32'(vecs[i].expData));
      chk($sformatf("v%0d hits", i), 32'(hc), 32'(vecs[i].expHc));
      chk($sformatf("v%0d misses", i), 32'(mc), 32'(vecs[i].expMc));
      endReq();
    end

    // Write-update policy: a write hit replaces the block.
    doReset();
    doReq(1, 10'h020, 1'b0, 32'h23222120, sawMiss, cyc);
    chk("p1 fill miss", 32'(sawMiss), 32'd1);
    endReq();
    doReq(1, 10'h020, 1'b1, 32'h12345678, sawMiss, cyc);
    chk("p1 write miss", 32'(sawMiss), 32'd0);
    chk("p1 write cycles", 32'(cyc), 32'd1);
    endReq();
    doReq(1, 10'h022, 1'b0, 32'h0, sawMiss, cyc);
    chk("p1 read miss", 32'(sawMiss), 32'd0);
    chk("p1 read data", 32'(dOut), 32'h34);
    chk("p1 hits", 32'(hc), 32'd1);
    endReq();

    // Three extra lookup cycles.
    doReset();
    doReq(3, 10'h000, 1'b0, 32'hDDCCBBAA, sawMiss, cyc);
    chk("d3 miss", 32'(sawMiss), 32'd1);
    chk("d3 miss cycles", 32'(cyc), 32'd5);
    chk("d3 miss data", 32'(dOut), 32'hAA);
    endReq();
    doReq(3, 10'h001, 1'b0, 32'h0, sawMiss, cyc);
    chk("d3 hit miss", 32'(sawMiss), 32'd0);
    chk("d3 hit cycles", 32'(cyc), 32'd4);
    chk("d3 hit data", 32'(dOut), 32'hBB);
    endReq();

    // Enable dropped while waiting for the fill.
    doReset();
    sel = 0; addr = 10'h100; wr = 1'b0; din = 32'hAAAA5555; en = 1'b1;
    tick(); tick();
    chk("abort inFill", 32'(ms), 32'd1);
    en = 1'b0;
    tick();
    chk("abort missLow", 32'(ms), 32'd0);
    fr = 1'b1;
    tick();
    fr = 1'b0;
    tick();
    chk("abort noDone", 32'(fc), 32'd0);
    chk("abort noData", 32'(dOut), 32'd0);
    chk("abort misses", 32'(mc), 32'd1);
    doReq(0, 10'h100, 1'b0, 32'h44332211, sawMiss, cyc);
    chk("abort reread miss", 32'(sawMiss), 32'd1);
    chk("abort reread misses", 32'(mc), 32'd2);
    endReq();

    // Reset asserted while waiting for the fill.
    doReq(0, 10'h000, 1'b0, 32'hDDCCBBAA, sawMiss, cyc);
    chk("rfill data", 32'(dOut), 32'hAA);
    endReq();
    addr = 10'h040; wr = 1'b0; en = 1'b1;
    tick(); tick();
    chk("rmid inFill", 32'(ms), 32'd1);
    #1 rstN = 1'b0;
    #1;
    chk("rmid miss", 32'(ms), 32'd0);
    chk("rmid done", 32'(fc), 32'd0);
    chk("rmid data", 32'(dOut), 32'd0);
    chk("rmid misses", 32'(mc), 32'd0);
    en = 1'b0;
    tick(); tick();
    rstN = 1'b1;
    tick();
    doReq(0, 10'h000, 1'b0, 32'hDDCCBBAA, sawMiss, cyc);
    chk("rmid reread miss", 32'(sawMiss), 32'd1);
    chk("rmid reread misses", 32'(mc), 32'd1);
    endReq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/assoc_cache_ctrl.md
# assoc_cache_ctrl

Parametrised N-way set-associative cache level with a registered FSM, configurable lookup latency, selectable write policy, true-LRU replacement and hit/miss statistics. It sits between an upper requester (core or upper cache level) and a lower level (next cache or main memory). Instances chain exactly like the current cache levels: this level's `miss` drives the lower level's `enable`, and the lower level's `fetchComplete` drives this level's `fetchReceive`.

## Interface
- `SIZE`, 128: total data capacity in bits; `SIZE/BLOCK_SIZE` must be divisible by `ASSOCIATIVITY`.
- `ADDR_LENGTH`, 10: byte-address width.
- `BLOCK_SIZE`, 32: block width in bits, power of 2, ≥ 8.
- `RETURN_SIZE`, 8: read return width; `BLOCK_SIZE` is a multiple of it.
- `ASSOCIATIVITY`, 4: ways per set, power of 2, ≥ 2.
- `CACHE_DELAY`, 0: extra lookup cycles before tag compare.
- `WRITE_POLICY`, 0: 0 = write-around, invalidating on hit; 1 = write-around, updating the block on hit.
- `STAT_WIDTH`, 16: width of the hit and miss counters.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low.
- `addr_in`, in, `ADDR_LENGTH`: request address, latched on accept.
- `data_in`, in, `BLOCK_SIZE`: write block, or fill block from the lower level.
- `enable`, in, 1: request; held high until `fetchComplete`.
- `write`, in, 1: request type, latched on accept.
- `fetchReceive`, in, 1: lower level has the fill block on `data_in`.
- `data_out`, out, `RETURN_SIZE`: registered read data.
- `fetchComplete`, out, 1: request finished.
- `miss`, out, 1: lower-level request, held until fill.
- `hit_count`, out, `STAT_WIDTH`: read hits, saturating.
- `miss_count`, out, `STAT_WIDTH`: read misses, saturating.

## Operation
- Address fields: byte select is `log2(BLOCK_SIZE/RETURN_SIZE)` LSBs, then set index `log2(SIZE/BLOCK_SIZE/ASSOCIATIVITY)`, then the remaining bits are the tag.
- Reset (low): all valid bits cleared, LRU state cleared, FSM → IDLE. All outputs are 0 and both counters are 0. Reset takes effect mid-operation too and abandons any pending fill.
- FSM states: IDLE, LOOKUP, FILL, DONE.
  - IDLE: with `enable`=1, latch `addr_in`, `write` and (for writes) `data_in`, then go to LOOKUP and load the delay counter with `CACHE_DELAY`.
  - LOOKUP: while the counter is nonzero, decrement it. At zero, compare the tag against all ways of the set.
    - Read hit: `data_out` ← selected `RETURN_SIZE` slice (slice 0 at the LSBs); mark the way MRU; increment `hit_count`; go to DONE.
    - Read miss: choose a victim (lowest-index invalid way, else the LRU way); increment `miss_count`; go to FILL.
    - Write hit: policy 0 clears the valid bit; policy 1 replaces the block with the latched data and marks it MRU. Go to DONE.
    - Write miss: no change; go to DONE.
  - FILL: `miss`=1. When `fetchReceive`=1, write `data_in` plus the tag and valid bit into the victim way, mark it MRU, set `data_out` from `data_in` at the latched byte select, and go to DONE.
  - DONE: `fetchComplete`=1. Stay until `enable`=0, then go to IDLE.
- `enable` falling in LOOKUP or FILL aborts to IDLE with no array update and no counter change. `fetchReceive` outside FILL is ignored.
- Writes never allocate and never assert `miss`. The lower level sees writes directly on the shared `write` line.
- Counters hold at all-ones once reached.

## Timing
- Accept on edge 0. Compare at edge `CACHE_DELAY+1`. On a hit, `fetchComplete` and `data_out` are valid from edge `CACHE_DELAY+1`, so with `CACHE_DELAY`=0 a hit takes 1 cycle.
- On a miss, `miss` rises after edge `CACHE_DELAY+1`. Once `fetchReceive` is sampled high at edge F, `miss` is low and `fetchComplete` is high after edge F.
- `fetchComplete` stays high while in DONE. A new request needs one IDLE cycle with `enable`=0.
- Every output is registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `cache_pkg`: FSM state enum, and functions for field widths and the field-extract helpers.
- Sub-module `cache_lru`: per-set age matrix with `ASSOCIATIVITY` entries of `log2(ASSOCIATIVITY)` bits each. Provides a touch port (set, way) and a victim query (set → LRU way). It uses the same clock and reset.

## Test plan
- Cold read at 0x000 (defaults): `miss`=1, lower returns 0xDDCCBBAA, `data_out`=0xAA, `fetchComplete`=1, `miss_count`=1. Rereading 0x001 gives a 1-cycle hit, `data_out`=0xBB, `hit_count`=1.
- Fill 5 addresses mapping to set 0 (0x00, 0x20, 0x40, 0x60, 0x80; 4 ways): the 5th evicts 0x00. Rereading 0x20 hits; rereading 0x00 misses.
- Policy 0: write 0x20 after a fill, then read 0x20 → `miss`=1. Policy 1: write 0x12345678 to 0x20, then read 0x22 → hit, `data_out`=0x34.
- `CACHE_DELAY`=3: a hit raises `fetchComplete` exactly 4 cycles after accept.
- Drop `enable` mid-FILL, then pulse `fetchReceive`: no fill happens, the FSM returns to IDLE, and a later read still misses.
- Assert `reset` mid-FILL: all outputs go to 0 asynchronously. After release, a previously filled address misses.
